// File: rtl/reg_file_unit_pkg.sv
// Shared constants for the register file: word length, register count,
// address width and the hard-wired zero register index.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package reg_file_unit_pkg;

    localparam int WORD_LENGTH  = `WORD_LENGTH;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADR_LEN_DEF  = 4;
    localparam int R0_IDX       = 0;

endpackage

// File: rtl/reg_file_unit_scoreboard.sv
// Pending-register scoreboard: one bit per register, set on reserve, cleared
// on write. Reserve beats write when both target the same register. R0 is
// never pending. The lookup hides a pending bit whose write lands this cycle.
module reg_file_scoreboard
    import reg_file_unit_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADR_LEN  = ADR_LEN_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wen_i,
    input  logic [ADR_LEN-1:0] wadr_i,
    input  logic               resen_i,
    input  logic [ADR_LEN-1:0] resadr_i,
    input  logic [ADR_LEN-1:0] radra_i,
    input  logic [ADR_LEN-1:0] radrb_i,
    output logic               penda_o,
    output logic               pendb_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Next pending vector: clear on write first so a same-cycle reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (wen_i) begin
            pend_d[wadr_i] = 1'b0;
        end
        if (resen_i) begin
            pend_d[resadr_i] = 1'b1;
        end
        pend_d[R0_IDX] = 1'b0;
    end

    // Pending bit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Per-port lookup; an arriving write to the same register resolves the hazard.
    always_comb begin
        penda_o = pend_q[radra_i] && !(wen_i && (wadr_i == radra_i));
        pendb_o = pend_q[radrb_i] && !(wen_i && (wadr_i == radrb_i));
    end

endmodule

// File: rtl/reg_file_unit.sv
// General register file: one write port, two registered read ports with
// write bypass, R0 reads as zero, pending scoreboard driving a stall flag.
// Optional feature macro: REG_FILE_PARITY_EN adds one even-parity bit per
// register and a registered parity error flag; otherwise parErr is 0.
module reg_file_unit
    import reg_file_unit_pkg::*;
#(
    parameter int WORD_LEN = WORD_LENGTH,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADR_LEN  = ADR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wEn,
    input  logic [ADR_LEN-1:0]  wAdr,
    input  logic [WORD_LEN-1:0] wData,
    input  logic [ADR_LEN-1:0]  rAdrA,
    input  logic [ADR_LEN-1:0]  rAdrB,
    input  logic                rEn,
    input  logic                resEn,
    input  logic [ADR_LEN-1:0]  resAdr,
    output logic [WORD_LEN-1:0] qA,
    output logic [WORD_LEN-1:0] qB,
    output logic                stall,
    output logic                parErr
);

    localparam logic [ADR_LEN-1:0] R0_ADR = ADR_LEN'(R0_IDX);

    logic [WORD_LEN-1:0] regs_q [NUM_REGS];
    logic [WORD_LEN-1:0] qA_q, qA_d, qB_q, qB_d;
    logic                stall_q, stall_d;
    logic                byp_a, byp_b;
    logic [WORD_LEN-1:0] val_a, val_b;
    logic                pend_a, pend_b;
    logic                wr_ok;

    assign wr_ok = wEn && (wAdr != R0_ADR);

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADR_LEN  (ADR_LEN)
    ) u_scoreboard (
        .clk_i    (clk),
        .rst_ni   (rst),
        .wen_i    (wr_ok),
        .wadr_i   (wAdr),
        .resen_i  (resEn && (resAdr != R0_ADR)),
        .resadr_i (resAdr),
        .radra_i  (rAdrA),
        .radrb_i  (rAdrB),
        .penda_o  (pend_a),
        .pendb_o  (pend_b)
    );

    // Storage array; R0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wAdr] <= wData;
        end
    end

    // Operand selection: zero register, then write bypass, then storage.
    always_comb begin
        byp_a   = wEn && (wAdr == rAdrA);
        byp_b   = wEn && (wAdr == rAdrB);
        val_a   = (rAdrA == R0_ADR) ? '0 : (byp_a ? wData : regs_q[rAdrA]);
        val_b   = (rAdrB == R0_ADR) ? '0 : (byp_b ? wData : regs_q[rAdrB]);
        qA_d    = rEn ? val_a : qA_q;
        qB_d    = rEn ? val_b : qB_q;
        stall_d = rEn ? (pend_a || pend_b) : stall_q;
    end

    // Read-port output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qA_q    <= '0;
            qB_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            qA_q    <= qA_d;
            qB_q    <= qB_d;
            stall_q <= stall_d;
        end
    end

    assign qA    = qA_q;
    assign qB    = qB_q;
    assign stall = stall_q;

`ifdef REG_FILE_PARITY_EN
    logic par_q [NUM_REGS];
    logic parErr_q, parErr_d;
    logic bad_a, bad_b;

    // Stored even-parity bit per register, recomputed on every accepted write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                par_q[i] <= 1'b0;
            end
        end else if (wr_ok) begin
            par_q[wAdr] <= ^wData;
        end
    end

    // Only stored, non-R0 operands are checked; bypassed data is fresh.
    always_comb begin
        bad_a    = (rAdrA != R0_ADR) && !byp_a && ((^regs_q[rAdrA]) != par_q[rAdrA]);
        bad_b    = (rAdrB != R0_ADR) && !byp_b && ((^regs_q[rAdrB]) != par_q[rAdrB]);
        parErr_d = rEn ? (bad_a || bad_b) : parErr_q;
    end

    // Parity error flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parErr_q <= 1'b0;
        end else begin
            parErr_q <= parErr_d;
        end
    end

    assign parErr = parErr_q;
`else
    assign parErr = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_unit.sv
// Bench for reg_file_unit: an array-level model updated on each rising edge,
// a per-cycle compare on the falling edge, and literal checks after vectors.
`timescale 1ns/1ps
module tb_reg_file_unit;

    logic        clk;
    logic        rst;
    logic        wEn;
    logic [3:0]  wAdr;
    logic [31:0] wData;
    logic [3:0]  rAdrA;
    logic [3:0]  rAdrB;
    logic        rEn;
    logic        resEn;
    logic [3:0]  resAdr;
    logic [31:0] qA;
    logic [31:0] qB;
    logic        stall;
    logic        parErr;

    int n_chk  = 0;
    int n_fail = 0;

    reg_file_unit dut (
        .clk    (clk),
        .rst    (rst),
        .wEn    (wEn),
        .wAdr   (wAdr),
        .wData  (wData),
        .rAdrA  (rAdrA),
        .rAdrB  (rAdrB),
        .rEn    (rEn),
        .resEn  (resEn),
        .resAdr (resAdr),
        .qA     (qA),
        .qB     (qB),
        .stall  (stall),
        .parErr (parErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: architectural registers, pending set, corrupted-parity set.
    logic [31:0] m_reg  [16];
    logic        m_pend [16];
    logic        m_flip [16];
    logic [31:0] m_qA, m_qB;
    logic        m_stall, m_par;

    function automatic logic [31:0] m_val(input logic [3:0] a);
        if (a == 4'd0) return 32'h0;
        if (wEn && wAdr == a) return wData;
        return m_reg[a];
    endfunction

    function automatic logic m_busy(input logic [3:0] a);
        return (a != 4'd0) && m_pend[a] && !(wEn && wAdr == a);
    endfunction

    function automatic logic m_bad(input logic [3:0] a);
        return (a != 4'd0) && !(wEn && wAdr == a) && m_flip[a];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] = 32'h0; m_pend[i] = 1'b0; m_flip[i] = 1'b0;
            end
            m_qA = 32'h0; m_qB = 32'h0; m_stall = 1'b0; m_par = 1'b0;
        end else begin
            if (rEn) begin
                m_qA    = m_val(rAdrA);
                m_qB    = m_val(rAdrB);
                m_stall = m_busy(rAdrA) || m_busy(rAdrB);
                m_par   = m_bad(rAdrA) || m_bad(rAdrB);
            end
            if (wEn && wAdr != 4'd0) begin
                m_reg[wAdr]  = wData;
                m_pend[wAdr] = 1'b0;
                m_flip[wAdr] = 1'b0;
            end
            if (resEn && resAdr != 4'd0) m_pend[resAdr] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every falling edge the DUT outputs must equal the model.
    always @(negedge clk) begin
        chk("cyc_qA", qA, m_qA);
        chk("cyc_qB", qB, m_qB);
        chk("cyc_stall", {31'h0, stall}, {31'h0, m_stall});
        chk("cyc_parErr", {31'h0, parErr}, {31'h0, m_par});
    end

    // Apply one vector, let one rising edge take it, return 2ns after the edge.
    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb, input logic re,
                         input logic rs, input logic [3:0] rsa);
        wEn = we; wAdr = wa; wData = wd; rAdrA = ra; rAdrB = rb;
        rEn = re; resEn = rs; resAdr = rsa;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b0;
        wEn = 1'b1; wAdr = 4'd6; wData = 32'hFFFF_0000;
        rAdrA = 4'd6; rAdrB = 4'd6; rEn = 1'b1; resEn = 1'b1; resAdr = 4'd6;
        #22;
        rst = 1'b1;
        wEn = 1'b0; rEn = 1'b0; resEn = 1'b0;
        #1;
        chk("rst_qA", qA, 32'h0);
        chk("rst_qB", qB, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_parErr", {31'h0, parErr}, 32'h0);
        @(posedge clk); #2;

        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(i), 1'b1, 1'b0, 4'd0);
            chk("post_rst_read", qA | qB, 32'h0);
        end
        chk("post_rst_stall", {31'h0, stall}, 32'h0);

        drive(1'b1, 4'd3, 32'h1234_5678, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("wr_rd_qA", qA, 32'h1234_5678);
        chk("wr_rd_qB", qB, 32'h0);

        drive(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd5, 1'b1, 1'b0, 4'd0);
        chk("byp_qA", qA, 32'hDEAD_BEEF);
        chk("byp_qB", qB, 32'hDEAD_BEEF);

        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd5, 1'b0, 1'b0, 4'd0);
        chk("hold_qA", qA, 32'hDEAD_BEEF);

        drive(1'b1, 4'd0, 32'hFFFF_FFFF, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0);
        drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd3, 1'b1, 1'b0, 4'd0);
        chk("r0_qA", qA, 32'h0);
        chk("r0_qB", qB, 32'h1234_5678);
        chk("r0_stall", {31'h0, stall}, 32'h0);

        drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd7, 1'b1, 1'b1, 4'd7);
        chk("res_same_cyc_stall", {31'h0, stall}, 32'h0);
        drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("res_stall", {31'h0, stall}, 32'h1);
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd7, 1'b1, 1'b0, 4'd0);
        chk("res_stall_portB", {31'h0, stall}, 32'h1);
        drive(1'b1, 4'd7, 32'h0000_0042, 4'd7, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("wr_clear_stall", {31'h0, stall}, 32'h0);
        chk("wr_clear_qA", qA, 32'h0000_0042);
        drive(1'b1, 4'd7, 32'h0000_0099, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7);
        drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd7, 1'b1, 1'b0, 4'd0);
        chk("res_wins_stall", {31'h0, stall}, 32'h1);
        chk("res_wins_qA", qA, 32'h0000_0099);
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 1'b0, 1'b0, 4'd0);
        chk("hold_stall", {31'h0, stall}, 32'h1);
        chk("hold_qB", qB, 32'h0000_0099);

        drive(1'b1, 4'd10, 32'hA5A5_A5A5, 4'd0, 4'd0, 1'b0, 1'b1, 4'd11);
        wEn = 1'b1; wAdr = 4'd12; wData = 32'h1111_2222;
        resEn = 1'b1; resAdr = 4'd12;
        rst = 1'b0;
        #4;
        rst = 1'b1;
        wEn = 1'b0; resEn = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 4'd10, 4'd12, 1'b1, 1'b0, 4'd0);
        chk("midrst_qA", qA, 32'h0);
        chk("midrst_qB", qB, 32'h0);
        drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd11, 1'b1, 1'b0, 4'd0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);

`ifdef REG_FILE_PARITY_EN
        drive(1'b1, 4'd2, 32'h0000_0001, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 4'd4, 32'h0000_0003, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
        dut.par_q[2] = ~dut.par_q[2];
        m_flip[2] = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("par_err", {31'h0, parErr}, 32'h1);
        drive(1'b0, 4'd0, 32'h0, 4'd4, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("par_ok", {31'h0, parErr}, 32'h0);
        drive(1'b0, 4'd0, 32'h0, 4'd4, 4'd2, 1'b1, 1'b0, 4'd0);
        chk("par_err_portB", {31'h0, parErr}, 32'h1);
        drive(1'b1, 4'd2, 32'h0000_0007, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("par_byp", {31'h0, parErr}, 32'h0);
        drive(1'b0, 4'd0, 32'h0, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0);
        chk("par_rewritten", {31'h0, parErr}, 32'h0);
`endif

        idle();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
